pipelined_cs_resolver: RTL and testbench

- Parametrised successor to the fixed 256-bit, 1/2-stage carry-save resolver.
- Converts a carry-save pair (sum vector, carry vector) plus the final full-adder carry-out of the 3:2 compressor tree into one binary result.
- Generalised to WIDTH bits and STAGES segment pipeline stages, with LSB carry-in, a passthrough tag and a valid/ready handshake with per-stage bubble collapsing.
- Sits between the IDDMM 3:2 compressor array and the modular-reduction / result buffers.

---
 rtl/pipelined_cs_resolver_pkg.sv | 32 +++
 rtl/pipelined_cs_resolver_stage.sv | 90 +++++++++
 rtl/pipelined_cs_resolver.sv | 97 +++++++++
 tb/tb_pipelined_cs_resolver.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_cs_resolver_pkg.sv
`default_nettype none
// ============================================================================
// iddmm_pkg : shared sizing helpers and configuration checks for the
//             pipelined carry-save resolver.
// Rev 1.0
// ============================================================================
package iddmm_pkg;

  localparam int MAX_STAGES = 8;
  localparam int SUM_EXTRA  = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int seg_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

  function automatic int sum_width(input int width);
    return width + SUM_EXTRA;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= MAX_STAGES) && ((width % stages) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_cs_resolver_stage.sv
`default_nettype none
// ============================================================================
// cs_resolve_stage : resolves one segment of a carry-save pair and forwards
//                    the still-raw segments, tag and valid bit.
// Rev 1.0
// ============================================================================
module cs_resolve_stage
  import iddmm_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int SEG   = 128,
  parameter int IDX   = 0,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             ld_next_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             ffc_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic             ld_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             carry_o,
  output logic             ffc_o,
  output logic [1:0]       top_o,
  output logic [TAG_W-1:0] tag_o
);

  logic [SEG:0]       seg_sum_w;
  logic [WIDTH-1:0]   a_d;
  logic [1:0]         top_d;
  logic               ld_w;

  logic               valid_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic               ffc_q;
  logic [1:0]         top_q;
  logic [TAG_W-1:0]   tag_q;

  assign seg_sum_w = {1'b0, a_i[IDX*SEG +: SEG]}
                   + {1'b0, b_i[IDX*SEG +: SEG]}
                   + {{SEG{1'b0}}, carry_i};

  // Resolved segment overwrites its slot in the sum vector; the rest rides along.
  always_comb begin
    a_d                  = a_i;
    a_d[IDX*SEG +: SEG]  = seg_sum_w[SEG-1:0];
  end

  assign top_d = {1'b0, seg_sum_w[SEG]} + {1'b0, ffc_i};
  assign ld_w  = ~valid_q | ld_next_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      ffc_q   <= 1'b0;
      top_q   <= '0;
      tag_q   <= '0;
    end else if (ld_w) begin
      valid_q <= valid_i;
      a_q     <= a_d;
      b_q     <= b_i;
      carry_q <= seg_sum_w[SEG];
      ffc_q   <= ffc_i;
      top_q   <= top_d;
      tag_q   <= tag_i;
    end
  end

  assign valid_o = valid_q;
  assign ld_o    = ld_w;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign carry_o = carry_q;
  assign ffc_o   = ffc_q;
  assign top_o   = top_q;
  assign tag_o   = tag_q;

endmodule
`default_nettype wire

// File: rtl/pipelined_cs_resolver.sv
`default_nettype none
// ============================================================================
// pipelined_cs_resolver : segment-pipelined carry-save to binary resolver
//                         with valid/ready handshake and bubble collapsing.
// Rev 1.0
// ============================================================================
module pipelined_cs_resolver
  import iddmm_pkg::*;
#(
  parameter int WIDTH  = 256,
  parameter int STAGES = 2,
  parameter int TAG_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            ain,
  input  logic [WIDTH-1:0]            bin,
  input  logic                        cin_i,
  input  logic                        final_fa_cout_i,
  input  logic [TAG_W-1:0]            tag_i,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [sum_width(WIDTH)-1:0] full_sum,
  output logic [TAG_W-1:0]            tag_o
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipelined_cs_resolver: STAGES must be 1..8 and divide WIDTH");
  end

  logic [STAGES:0]        w_valid;
  logic [STAGES:1]        w_ld;
  logic [WIDTH-1:0]       w_a   [0:STAGES];
  logic [WIDTH-1:0]       w_b   [0:STAGES];
  logic [STAGES:0]        w_carry;
  logic [STAGES:0]        w_ffc;
  logic [TAG_W-1:0]       w_tag [0:STAGES];
  logic [STAGES:1][1:0]   w_top;
  logic                   w_unused;

  assign w_valid[0] = in_valid;
  assign w_a[0]     = ain;
  assign w_b[0]     = bin;
  assign w_carry[0] = cin_i;
  assign w_ffc[0]   = final_fa_cout_i;
  assign w_tag[0]   = tag_i;

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    logic ld_next_w;

    // A stage may advance when any stage downstream of it has a hole or the
    // consumer is taking the head; computed flat from the valid bits.
    if (k == STAGES) begin : g_tail
      assign ld_next_w = out_ready;
    end else begin : g_body
      assign ld_next_w = out_ready | ~(&w_valid[STAGES:k+1]);
    end

    cs_resolve_stage #(
      .WIDTH (WIDTH),
      .SEG   (SEG),
      .IDX   (k - 1),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (w_valid[k-1]),
      .ld_next_i (ld_next_w),
      .a_i       (w_a[k-1]),
      .b_i       (w_b[k-1]),
      .carry_i   (w_carry[k-1]),
      .ffc_i     (w_ffc[k-1]),
      .tag_i     (w_tag[k-1]),
      .valid_o   (w_valid[k]),
      .ld_o      (w_ld[k]),
      .a_o       (w_a[k]),
      .b_o       (w_b[k]),
      .carry_o   (w_carry[k]),
      .ffc_o     (w_ffc[k]),
      .top_o     (w_top[k]),
      .tag_o     (w_tag[k])
    );
  end

  assign in_ready  = w_ld[1] & ~rst;
  assign out_valid = w_valid[STAGES];
  assign full_sum  = {w_top[STAGES], w_a[STAGES]};
  assign tag_o     = w_tag[STAGES];

  assign w_unused = ^{w_b[STAGES], w_carry[STAGES], w_ffc[STAGES], w_ld, w_top};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cs_resolver.sv
`default_nettype none
// ============================================================================
// tb_pipelined_cs_resolver : directed and randomized checks of the resolver
//                            at 256/2 and 16/4 against an arithmetic FIFO model.
// Rev 1.0
// ============================================================================
module tb_pipelined_cs_resolver;

  localparam int S16 = 4;

  logic clk = 1'b0;
  logic rst;

  logic        iv16, ir16, ov16, or16, cin16, ffc16;
  logic [15:0] a16, b16;
  logic [7:0]  ti16, to16;
  logic [17:0] fs16;

  logic         iv256, ir256, ov256, or256, cin256, ffc256;
  logic [255:0] a256, b256;
  logic [7:0]   ti256, to256;
  logic [257:0] fs256;

  int checks   = 0;
  int failures = 0;
  bit acc16;

  logic [17:0]  q_sum [$];
  logic [7:0]   q_tag [$];
  logic [257:0] e256_sum [0:5];
  logic [7:0]   e256_tag [0:5];

  always #5 clk = ~clk;

  pipelined_cs_resolver #(.WIDTH(16), .STAGES(4), .TAG_W(8)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .ain(a16), .bin(b16),
    .cin_i(cin16), .final_fa_cout_i(ffc16), .tag_i(ti16), .out_valid(ov16),
    .out_ready(or16), .full_sum(fs16), .tag_o(to16)
  );

  pipelined_cs_resolver #(.WIDTH(256), .STAGES(2), .TAG_W(8)) u_dut256 (
    .clk(clk), .rst(rst), .in_valid(iv256), .in_ready(ir256), .ain(a256), .bin(b256),
    .cin_i(cin256), .final_fa_cout_i(ffc256), .tag_i(ti256), .out_valid(ov256),
    .out_ready(or256), .full_sum(fs256), .tag_o(to256)
  );

  task automatic chk_vec(input string tag, input logic [259:0] obs, input logic [259:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] ref16();
    return 18'(a16) + 18'(b16) + 18'(cin16) + (18'(ffc16) << 16);
  endfunction

  function automatic logic [257:0] ref256();
    return 258'(a256) + 258'(b256) + 258'(cin256) + (258'(ffc256) << 256);
  endfunction

  task automatic rand16();
    a16   = 16'($urandom());
    b16   = 16'($urandom());
    cin16 = 1'($urandom());
    ffc16 = 1'($urandom());
    ti16  = 8'($urandom());
  endtask

  task automatic rand256();
    for (int i = 0; i < 8; i++) begin
      a256[i*32 +: 32] = $urandom();
      b256[i*32 +: 32] = $urandom();
    end
    cin256 = 1'($urandom());
    ffc256 = 1'($urandom());
    ti256  = 8'($urandom());
  endtask

  // One cycle of the 16/4 instance: model the FIFO (capacity S16), check the
  // handshake and the head result, then advance one clock.
  task automatic tick16();
    logic exp_ready;
    #1;
    exp_ready = !rst && ((q_sum.size() < S16) || or16);
    chk_bit("in_ready16", ir16, exp_ready);
    if (q_sum.size() == 0) begin
      chk_bit("idle_out_valid16", ov16, 1'b0);
    end else if (ov16) begin
      chk_vec("full_sum16", 260'(fs16), 260'(q_sum[0]));
      chk_vec("tag16", 260'(to16), 260'(q_tag[0]));
    end
    acc16 = iv16 && ir16 && !rst;
    if (rst) begin
      q_sum.delete();
      q_tag.delete();
    end else begin
      if (ov16 && or16 && q_sum.size() > 0) begin
        q_sum.delete(0);
        q_tag.delete(0);
      end
      if (acc16) begin
        q_sum.push_back(ref16());
        q_tag.push_back(ti16);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0; ffc16 = 1'b0; ti16 = '0;
    iv256 = 1'b0; or256 = 1'b1; a256 = '0; b256 = '0; cin256 = 1'b0; ffc256 = 1'b0; ti256 = '0;

    // Reset state
    @(negedge clk);
    #1;
    chk_bit("in_ready256_rst", ir256, 1'b0);
    tick16();
    rst = 1'b0;
    #1;
    chk_bit("rst_out_valid16", ov16, 1'b0);
    chk_vec("rst_full_sum16", 260'(fs16), 260'd0);
    chk_vec("rst_tag16", 260'(to16), 260'd0);
    chk_bit("rst_out_valid256", ov256, 1'b0);
    chk_vec("rst_full_sum256", 260'(fs256), 260'd0);
    chk_bit("in_ready256", ir256, 1'b1);

    // 256/2: carry through both stages
    a256 = {256{1'b1}}; b256 = 256'd1; cin256 = 1'b0; ffc256 = 1'b1; ti256 = 8'h5A; iv256 = 1'b1;
    cyc();
    iv256 = 1'b0;
    chk_bit("lat256_a_t1", ov256, 1'b0);
    cyc();
    chk_bit("lat256_a_t2", ov256, 1'b1);
    chk_vec("carry256_sum", 260'(fs256), 260'({2'b10, {256{1'b0}}}));
    chk_vec("carry256_tag", 260'(to256), 260'(8'h5A));
    cyc();
    chk_bit("drain256_a", ov256, 1'b0);

    // 256/2: maximum operands
    a256 = {256{1'b1}}; b256 = {256{1'b1}}; cin256 = 1'b1; ffc256 = 1'b1; ti256 = 8'hC3; iv256 = 1'b1;
    cyc();
    iv256 = 1'b0;
    cyc();
    chk_bit("lat256_b_t2", ov256, 1'b1);
    chk_vec("max256_sum", 260'(fs256), 260'({2'b10, {256{1'b1}}}));
    chk_vec("max256_tag", 260'(to256), 260'(8'hC3));

    // 256/2: back-to-back random operands
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        rand256();
        iv256 = 1'b1;
        e256_sum[i] = ref256();
        e256_tag[i] = ti256;
      end else begin
        iv256 = 1'b0;
      end
      #1;
      if (i < 6) chk_bit("b2b256_in_ready", ir256, 1'b1);
      if (i >= 2) begin
        chk_bit("b2b256_out_valid", ov256, 1'b1);
        chk_vec("b2b256_sum", 260'(fs256), 260'(e256_sum[i-2]));
        chk_vec("b2b256_tag", 260'(to256), 260'(e256_tag[i-2]));
      end
      cyc();
    end
    chk_bit("b2b256_done", ov256, 1'b0);

    // 16/4: carry rippling through every segment
    a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1; ffc16 = 1'b0; ti16 = 8'h11; iv16 = 1'b1; or16 = 1'b1;
    tick16();
    iv16 = 1'b0;
    for (int i = 1; i < S16; i++) begin
      chk_bit("lat16_early", ov16, 1'b0);
      tick16();
    end
    chk_bit("lat16_t4", ov16, 1'b1);
    chk_vec("chain16_sum", 260'(fs16), 260'(18'h10000));
    tick16();

    // 16/4: eight back-to-back random vectors
    for (int i = 0; i < 8; i++) begin
      rand16();
      iv16 = 1'b1;
      if (i >= S16) chk_bit("b2b16_out_valid", ov16, 1'b1);
      tick16();
    end
    iv16 = 1'b0;
    for (int i = 0; i < S16; i++) begin
      chk_bit("b2b16_tail_valid", ov16, 1'b1);
      tick16();
    end
    chk_bit("b2b16_done", ov16, 1'b0);

    // 16/4: backpressure, fill, stall, then simultaneous in/out on a full pipe
    or16 = 1'b0;
    for (int i = 0; i < S16; i++) begin
      rand16();
      iv16 = 1'b1;
      tick16();
    end
    rand16();
    tick16();
    tick16();
    chk_bit("stall16_out_valid", ov16, 1'b1);
    or16 = 1'b1;
    tick16();
    iv16 = 1'b0;
    for (int i = 0; i < S16; i++) begin
      chk_bit("drain16_valid", ov16, 1'b1);
      tick16();
    end
    chk_bit("drain16_done", ov16, 1'b0);

    // 16/4: bubble collapse with items on cycles 0, 3, 4
    or16 = 1'b0;
    rand16(); iv16 = 1'b1; tick16();
    iv16 = 1'b0; tick16(); tick16();
    rand16(); iv16 = 1'b1; tick16();
    rand16(); tick16();
    iv16 = 1'b0; tick16(); tick16();
    chk_bit("bubble16_head", ov16, 1'b1);
    rand16(); iv16 = 1'b1; tick16();
    iv16 = 1'b0; tick16();
    or16 = 1'b1;
    for (int i = 0; i < S16; i++) begin
      chk_bit("bubble16_drain", ov16, 1'b1);
      tick16();
    end
    chk_bit("bubble16_done", ov16, 1'b0);

    // 16/4: randomized traffic with random consumer stalls
    iv16 = 1'b0;
    acc16 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!iv16 || acc16) begin
        iv16 = ($urandom_range(0, 3) != 0);
        rand16();
      end
      or16 = ($urandom_range(0, 2) != 0);
      tick16();
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    repeat (S16 + 1) tick16();
    chk_bit("random16_drained", ov16, 1'b0);

    // 16/4: reset with three items in flight
    for (int i = 0; i < 3; i++) begin
      rand16();
      iv16 = 1'b1;
      tick16();
    end
    iv16 = 1'b0;
    rst = 1'b1;
    #1;
    chk_bit("rst16_in_ready", ir16, 1'b0);
    tick16();
    rst = 1'b0;
    #1;
    chk_bit("midrst_out_valid", ov16, 1'b0);
    chk_vec("midrst_full_sum", 260'(fs16), 260'd0);
    chk_vec("midrst_tag", 260'(to16), 260'd0);
    repeat (10) tick16();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
